// File: rtl/tlc_pkg.sv
// Shared definitions for the four-approach phase scheduler.
// Holds light codes, phase indices, controller states, approach bit
// positions and the helpers that map phases to approach masks and light codes.
// Approach masks are ordered {W, EL, NL, E}.
package tlc_pkg;

    // Light codes driven per approach; 2'b11 is never produced.
    localparam logic [1:0] LC_RED    = 2'b00;
    localparam logic [1:0] LC_GREEN  = 2'b01;
    localparam logic [1:0] LC_YELLOW = 2'b10;

    // Approach bit positions within a 4-bit approach mask.
    localparam int A_E  = 0;
    localparam int A_NL = 1;
    localparam int A_EL = 2;
    localparam int A_W  = 3;

    typedef enum logic [1:0] {
        P_EW     = 2'd0,
        P_ENL    = 2'd1,
        P_EL     = 2'd2,
        P_UNUSED = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } ctl_state_t;

    // Approaches that are green while a phase is active.
    // The unused index behaves as P_EW so a corrupted phase recovers there.
    function automatic logic [3:0] phase_mask(input phase_t p);
        case (p)
            P_EW:    phase_mask = 4'b1001;
            P_ENL:   phase_mask = 4'b0011;
            P_EL:    phase_mask = 4'b0100;
            default: phase_mask = 4'b1001;
        endcase
    endfunction

    // Round-robin successor: 0 -> 1 -> 2 -> 0.
    function automatic phase_t phase_succ(input phase_t p);
        case (p)
            P_EW:    phase_succ = P_ENL;
            P_ENL:   phase_succ = P_EL;
            default: phase_succ = P_EW;
        endcase
    endfunction

    // Packs four light codes {W, EL, NL, E}; green takes priority over yellow.
    function automatic logic [7:0] lights_for(input logic [3:0] green_mask,
                                              input logic [3:0] yellow_mask);
        logic [7:0] l;
        l = '0;
        for (int i = 0; i < 4; i++) begin
            if (green_mask[i])       l[2*i +: 2] = LC_GREEN;
            else if (yellow_mask[i]) l[2*i +: 2] = LC_YELLOW;
            else                     l[2*i +: 2] = LC_RED;
        end
        return l;
    endfunction

endpackage

// File: rtl/tlc_interval_timer.sv
// Loadable 4-bit down-counter that advances only on tick.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset, count returns to INIT
//   tick       - timebase enable; count decrements (saturating at 0)
//   load       - loads load_value; wins over the tick decrement
//   load_value - new interval length
//   count      - ticks left in the current interval
//   done       - high on the tick that ends the interval
module tlc_interval_timer #(
    parameter logic [3:0] INIT = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic       done
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= INIT;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // Intervals are never zero-length, so a count of 1 on a tick is the last tick.
    assign done = tick && (count <= 4'd1);

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven phase scheduler for the E / NL / EL / W intersection.
// Latches sensor requests, picks the next phase round-robin among phases
// with demand, and sequences GREEN -> YELLOW -> ALLRED with min/max green.
// Ports:
//   Clock, Reset          - clock and synchronous active-low reset
//   tick                  - single-cycle timebase enable
//   E, NL, EL, W          - approach sensors
//   etl, nltl, eltl, wtl  - light codes (RED=00, GREEN=01, YELLOW=10)
//   phase                 - active phase (outgoing phase during YELLOW/ALLRED)
//   ctl_state             - controller state GREEN/YELLOW/ALLRED
//   remaining             - ticks left in the current interval
//   req_pending           - latched requests {W, EL, NL, E}
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       tick,
    input  logic       E,
    input  logic       NL,
    input  logic       EL,
    input  logic       W,
    output logic [1:0] etl,
    output logic [1:0] nltl,
    output logic [1:0] eltl,
    output logic [1:0] wtl,
    output logic [1:0] phase,
    output logic [1:0] ctl_state,
    output logic [3:0] remaining,
    output logic [3:0] req_pending
);

    localparam logic [3:0] MIN_LEN  = 4'(MIN_GREEN);
    localparam logic [3:0] YEL_LEN  = 4'(YELLOW_T);
    localparam logic [3:0] AR_LEN   = 4'(ALLRED_T);
    localparam logic [3:0] MIN_LAST = 4'(MIN_GREEN - 1);
    localparam logic [3:0] MAX_LAST = 4'(MAX_GREEN - 1);

    ctl_state_t state_q;
    phase_t     phase_q;
    phase_t     target_q;
    logic [3:0] green_cnt;
    logic [3:0] req_q;
    logic [3:0] sens_q;
    logic [7:0] light_q;

    logic [3:0] sens;
    logic [3:0] green_now;
    phase_t     cur;
    phase_t     nxt1;
    phase_t     nxt2;
    phase_t     tgt;
    logic [3:0] cur_mask;
    logic       dem1;
    logic       dem2;
    logic       own;
    logic       exit_green;
    logic       timer_load;
    logic [3:0] timer_value;
    logic       timer_done;

    assign sens = {W, EL, NL, E};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            green_now[i] = (light_q[2*i +: 2] == LC_GREEN);
        end
    end

    assign cur      = (phase_q == P_UNUSED) ? P_EW : phase_q;
    assign cur_mask = phase_mask(cur);
    assign nxt1     = phase_succ(cur);
    assign nxt2     = phase_succ(nxt1);

    // Demand only counts approaches that are not already green now.
    assign dem1 = |(req_q & phase_mask(nxt1) & ~cur_mask);
    assign dem2 = |(req_q & phase_mask(nxt2) & ~cur_mask);
    assign tgt  = dem1 ? nxt1 : nxt2;

    // Registered sensors, so a sensor edge on a tick cycle counts from the next tick.
    assign own = |(sens_q & cur_mask);

    assign exit_green = tick && (state_q == ST_GREEN) && (green_cnt >= MIN_LAST)
                        && (dem1 || dem2) && (!own || (green_cnt >= MAX_LAST));

    always_comb begin
        timer_load  = 1'b0;
        timer_value = MIN_LEN;
        if (tick) begin
            case (state_q)
                ST_GREEN: begin
                    if (exit_green) begin
                        timer_load  = 1'b1;
                        timer_value = YEL_LEN;
                    end
                end
                ST_YELLOW: begin
                    if (timer_done) begin
                        timer_load  = 1'b1;
                        timer_value = AR_LEN;
                    end
                end
                ST_ALLRED: begin
                    if (timer_done) begin
                        timer_load  = 1'b1;
                        timer_value = MIN_LEN;
                    end
                end
                default: begin
                    timer_load  = 1'b1;
                    timer_value = MIN_LEN;
                end
            endcase
        end
    end

    tlc_interval_timer #(
        .INIT(MIN_LEN)
    ) u_timer (
        .clk       (Clock),
        .rst_n     (Reset),
        .tick      (tick),
        .load      (timer_load),
        .load_value(timer_value),
        .count     (remaining),
        .done      (timer_done)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_GREEN;
            phase_q   <= P_EW;
            target_q  <= P_EW;
            green_cnt <= 4'd0;
            req_q     <= 4'd0;
            sens_q    <= 4'd0;
            light_q   <= lights_for(phase_mask(P_EW), 4'b0000);
        end else begin
            sens_q <= sens;
            // A green approach is being served, so its clear beats a new set.
            req_q  <= (req_q | sens) & ~green_now;
            if (tick) begin
                case (state_q)
                    ST_GREEN: begin
                        phase_q <= cur;
                        if (exit_green) begin
                            state_q  <= ST_YELLOW;
                            target_q <= tgt;
                            light_q  <= lights_for(cur_mask & phase_mask(tgt),
                                                   cur_mask & ~phase_mask(tgt));
                        end else if (green_cnt != 4'd15) begin
                            green_cnt <= green_cnt + 4'd1;
                        end
                    end
                    ST_YELLOW: begin
                        if (timer_done) begin
                            state_q <= ST_ALLRED;
                            light_q <= lights_for(cur_mask & phase_mask(target_q), 4'b0000);
                        end
                    end
                    ST_ALLRED: begin
                        if (timer_done) begin
                            state_q   <= ST_GREEN;
                            phase_q   <= target_q;
                            green_cnt <= 4'd0;
                            light_q   <= lights_for(phase_mask(target_q), 4'b0000);
                        end
                    end
                    default: begin
                        state_q   <= ST_GREEN;
                        phase_q   <= P_EW;
                        green_cnt <= 4'd0;
                        light_q   <= lights_for(phase_mask(P_EW), 4'b0000);
                    end
                endcase
            end
        end
    end

    assign etl         = light_q[2*A_E  +: 2];
    assign nltl        = light_q[2*A_NL +: 2];
    assign eltl        = light_q[2*A_EL +: 2];
    assign wtl         = light_q[2*A_W  +: 2];
    assign phase       = phase_q;
    assign ctl_state   = state_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
module tb_tlc_phase_scheduler;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 12;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int BOUND     = 3 * (MAX_GREEN + YELLOW_T + ALLRED_T);
    localparam int RESET_VEC = {2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 4'd4, 4'b0000};

    // ---------------- clock / reset / DUT ----------------
    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       tick  = 1'b0;
    logic       E = 1'b0, NL = 1'b0, EL = 1'b0, W = 1'b0;
    logic [1:0] etl, nltl, eltl, wtl, phase, ctl_state;
    logic [3:0] remaining, req_pending;

    always #5 Clock = ~Clock;

    tlc_phase_scheduler #(
        .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
    ) dut (
        .Clock(Clock), .Reset(Reset), .tick(tick),
        .E(E), .NL(NL), .EL(EL), .W(W),
        .etl(etl), .nltl(nltl), .eltl(eltl), .wtl(wtl),
        .phase(phase), .ctl_state(ctl_state),
        .remaining(remaining), .req_pending(req_pending)
    );

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    function automatic logic [19:0] dut_vec();
        return {etl, nltl, eltl, wtl, phase, ctl_state, remaining, req_pending};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Interval view: mode (0 green, 1 yellow, 2 all-red), ticks elapsed in it,
    // and which approaches belong to which phase.
    int m_mode, m_phase, m_target, m_elapsed;
    bit m_req[4];
    bit m_sprev[4];

    function automatic bit in_phase(input int p, input int a);
        case (p)
            0: return (a == 0) || (a == 3);
            1: return (a == 0) || (a == 1);
            2: return (a == 2);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int light_of(input int a);
        bit now_g, next_g;
        now_g  = in_phase(m_phase, a);
        next_g = in_phase(m_target, a);
        if (m_mode == 0) return now_g ? 1 : 0;
        if (m_mode == 1) return (now_g && next_g) ? 1 : (now_g ? 2 : 0);
        return (now_g && next_g) ? 1 : 0;
    endfunction

    function automatic logic [19:0] model_out();
        logic [1:0] l0, l1, l2, l3, ph, md;
        logic [3:0] rem, rq;
        int r;
        if (m_mode == 0)      r = (m_elapsed >= MIN_GREEN) ? 0 : MIN_GREEN - m_elapsed;
        else if (m_mode == 1) r = YELLOW_T - m_elapsed;
        else                  r = ALLRED_T - m_elapsed;
        l0 = 2'(light_of(0)); l1 = 2'(light_of(1));
        l2 = 2'(light_of(2)); l3 = 2'(light_of(3));
        ph = 2'(m_phase); md = 2'(m_mode); rem = 4'(r);
        rq = {m_req[3], m_req[2], m_req[1], m_req[0]};
        return {l0, l1, l2, l3, ph, md, rem, rq};
    endfunction

    task automatic model_step(input logic [3:0] s, input bit t, input bit r);
        bit nreq[4];
        bit found, own;
        int p;
        if (!r) begin
            m_mode = 0; m_phase = 0; m_target = 0; m_elapsed = 0;
            for (int a = 0; a < 4; a++) begin m_req[a] = 0; m_sprev[a] = 0; end
            return;
        end
        for (int a = 0; a < 4; a++)
            nreq[a] = (light_of(a) == 1) ? 1'b0 : (m_req[a] | s[a]);
        if (t) begin
            case (m_mode)
                0: begin
                    found = 0; p = 0;
                    for (int d = 1; d <= 2 && !found; d++) begin
                        for (int a = 0; a < 4; a++)
                            if (in_phase((m_phase + d) % 3, a) && !in_phase(m_phase, a) && m_req[a])
                                found = 1;
                        if (found) p = (m_phase + d) % 3;
                    end
                    own = 0;
                    for (int a = 0; a < 4; a++)
                        if (in_phase(m_phase, a) && m_sprev[a]) own = 1;
                    if ((m_elapsed + 1 >= MIN_GREEN) && found &&
                        (!own || (m_elapsed + 1 >= MAX_GREEN))) begin
                        m_mode = 1; m_target = p; m_elapsed = 0;
                    end else if (m_elapsed < 15) begin
                        m_elapsed++;
                    end
                end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == YELLOW_T) begin m_mode = 2; m_elapsed = 0; end
                end
                default: begin
                    m_elapsed++;
                    if (m_elapsed == ALLRED_T) begin
                        m_mode = 0; m_phase = m_target; m_elapsed = 0;
                    end
                end
            endcase
        end
        for (int a = 0; a < 4; a++) begin m_req[a] = nreq[a]; m_sprev[a] = s[a]; end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] s, input bit t, input bit r);
        @(negedge Clock);
        Reset = r; tick = t;
        E = s[0]; NL = s[1]; EL = s[2]; W = s[3];
        model_step(s, t, r);
        exp_q.push_back(model_out());
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic wait_state(input logic [1:0] st, input logic [3:0] s,
                              input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            drive(s, 1'b1, 1'b1);
            if (ctl_state == st) begin n = k; break; end
        end
    endtask

    task automatic next_green(input logic [3:0] s, input int budget, output int ph);
        logic [1:0] start;
        start = phase;
        ph = -1;
        for (int k = 1; k <= budget; k++) begin
            drive(s, 1'b1, 1'b1);
            if (ctl_state == 2'd0 && phase != start) begin ph = int'(phase); break; end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [19:0] mon_exp, mon_act;
    int age[4];

    always @(posedge Clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = dut_vec();
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got l=%b ph=%0d st=%0d rem=%0d req=%b, expected l=%b ph=%0d st=%0d rem=%0d req=%b",
                         $time, mon_act[19:12], mon_act[11:10], mon_act[9:8], mon_act[7:4], mon_act[3:0],
                         mon_exp[19:12], mon_exp[11:10], mon_exp[9:8], mon_exp[7:4], mon_exp[3:0]);
            end
            checks++;
            if (etl == 2'b11 || nltl == 2'b11 || eltl == 2'b11 || wtl == 2'b11 ||
                (eltl != 2'b00 && (etl != 2'b00 || wtl != 2'b00)) ||
                (nltl != 2'b00 && wtl != 2'b00)) begin
                errors++;
                $display("FAIL conflict t=%0t: got e=%b nl=%b el=%b w=%b, expected no conflict and no code 11",
                         $time, etl, nltl, eltl, wtl);
            end
            for (int i = 0; i < 4; i++) begin
                if (!Reset) begin
                    age[i] = 0;
                end else if (req_pending[i]) begin
                    if (tick) age[i]++;
                end else if (age[i] > 0) begin
                    checks++;
                    if (age[i] > BOUND) begin
                        errors++;
                        $display("FAIL service_wait approach %0d: got %0d ticks, expected <= %0d", i, age[i], BOUND);
                    end
                    age[i] = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, ph;
        logic [3:0] s;
        for (int i = 0; i < 4; i++) age[i] = 0;

        // Reset state, then idle ticks keep P_EW green.
        do_reset();
        chk("reset_outputs", int'(dut_vec()), RESET_VEC);
        for (int k = 0; k < 20; k++) drive(4'b0000, 1'b1, 1'b1);
        chk("idle_hold", int'({phase, ctl_state, etl, wtl, remaining}), int'({2'b00, 2'b00, 2'b01, 2'b01, 4'd0}));

        // Single NL request: minimum green, yellow on W only, all-red, then P_ENL.
        do_reset();
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0010, 1'b1, 1'b1);
        chk("nl_latched", int'(req_pending), 4'b0010);
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 1'b1, 1'b1);
        chk("nl_yellow", int'({ctl_state, etl, wtl, remaining}), int'({2'b01, 2'b01, 2'b10, 4'd2}));
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 1'b1, 1'b1);
        chk("nl_allred", int'({ctl_state, etl, wtl, nltl}), int'({2'b10, 2'b01, 2'b00, 2'b00}));
        drive(4'b0000, 1'b1, 1'b1);
        chk("nl_green", int'({ctl_state, phase, etl, nltl, wtl}), int'({2'b00, 2'b01, 2'b01, 2'b01, 2'b00}));
        drive(4'b0000, 1'b0, 1'b1);
        chk("nl_cleared", int'(req_pending), 4'b0000);

        // E held with EL demand: P_EW yields only at max green.
        do_reset();
        drive(4'b0101, 1'b1, 1'b1);
        wait_state(2'b01, 4'b0001, 20, n);
        chk("max_green_ticks", n + 1, MAX_GREEN);
        chk("max_green_yellow", int'({etl, wtl}), int'({2'b10, 2'b10}));
        next_green(4'b0001, 10, ph);
        chk("max_green_next", ph, 2);
        chk("el_green", int'({eltl, etl, wtl}), int'({2'b01, 2'b00, 2'b00}));

        // Round robin: NL+EL from P_EW serves 1 then 2; E+W+NL from P_EL serves 0.
        do_reset();
        drive(4'b0110, 1'b1, 1'b1);
        next_green(4'b0000, 20, ph);
        chk("rr_first", ph, 1);
        next_green(4'b0000, 20, ph);
        chk("rr_second", ph, 2);
        drive(4'b1011, 1'b1, 1'b1);
        next_green(4'b0000, 30, ph);
        chk("rr_wrap", ph, 0);

        // Reset during yellow discards requests.
        do_reset();
        drive(4'b0010, 1'b1, 1'b1);
        wait_state(2'b01, 4'b0000, 10, n);
        chk("pre_reset_yellow", int'(ctl_state), 1);
        drive(4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0);
        chk("reset_in_yellow", int'(dut_vec()), RESET_VEC);
        drive(4'b0000, 1'b0, 1'b1);

        // Random sensors for 10k ticks with idle cycles mixed in.
        for (int k = 0; k < 10000; k++) begin
            for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 5) == 0);
            drive(s, 1'b1, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 5) == 0);
                drive(s, 1'b0, 1'b1);
            end
        end

        repeat (2) @(negedge Clock);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (age[i] > BOUND) begin
                errors++;
                $display("FAIL service_wait_end approach %0d: got %0d ticks, expected <= %0d", i, age[i], BOUND);
            end
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
